// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: merges ALU and buffered load results onto one write port, tracks busy regs.
// Latency: ALU accept -> oWrEn next cycle; load push -> oWrEn two cycles later at the earliest.
// Backpressure: both readies drop together when the load FIFO is full, and that cycle drains the FIFO head.
module rf_wb_arb #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LD_DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     iAluVld,
   output logic                     oAluRdy,
   input  logic [ADDR_WIDTH-1:0]    iAluAddr,
   input  logic [DATA_WIDTH-1:0]    iAluData,
   input  logic                     iLdVld,
   output logic                     oLdRdy,
   input  logic [ADDR_WIDTH-1:0]    iLdAddr,
   input  logic [DATA_WIDTH-1:0]    iLdData,
   input  logic                     iRsvEn,
   input  logic [ADDR_WIDTH-1:0]    iRsvAddr,
   output logic [2**ADDR_WIDTH-1:0] oBusy,
   output logic                     oWrEn,
   output logic [ADDR_WIDTH-1:0]    oWrAddr,
   output logic [DATA_WIDTH-1:0]    oWrData
);

   localparam int NREG = 2**ADDR_WIDTH;
   localparam int PW   = $clog2(LD_DEPTH);
   localparam int CW   = PW + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_ent_t;

   wb_ent_t         ld_mem [LD_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   ld_cnt;
   logic            ld_full;
   logic            ld_empty;
   logic            ld_push;
   logic            ld_pop;
   logic            alu_win;
   logic            gnt_vld;
   wb_ent_t         gnt;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_nxt;

   // Readies come from the registered count only, so no valid-to-ready path exists.
   assign ld_full  = (ld_cnt == CW'(LD_DEPTH));
   assign ld_empty = (ld_cnt == '0);
   assign oLdRdy   = !ld_full;
   assign oAluRdy  = !ld_full;

   assign alu_win  = iAluVld & !ld_full;
   assign ld_pop   = ld_full | (!iAluVld & !ld_empty);
   assign ld_push  = iLdVld & !ld_full;
   assign gnt_vld  = alu_win | ld_pop;

   always_comb begin
      gnt = ld_mem[rd_ptr];
      if (alu_win) begin
         gnt.addr = iAluAddr;
         gnt.data = iAluData;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ld_cnt <= '0;
      end else begin
         if (ld_push) wr_ptr <= wr_ptr + 1'b1;
         if (ld_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({ld_push, ld_pop})
            2'b10:   ld_cnt <= ld_cnt + 1'b1;
            2'b01:   ld_cnt <= ld_cnt - 1'b1;
            default: ld_cnt <= ld_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ld_push) ld_mem[wr_ptr] <= '{addr: iLdAddr, data: iLdData};
   end

   // Register 0 is hardwired: its grants are consumed but never written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oWrEn   <= 1'b0;
         oWrAddr <= '0;
         oWrData <= '0;
      end else begin
         oWrEn <= gnt_vld && (gnt.addr != '0);
         if (gnt_vld && (gnt.addr != '0)) begin
            oWrAddr <= gnt.addr;
            oWrData <= gnt.data;
         end
      end
   end

   // A reservation landing on the register being written this cycle wins over the clear.
   always_comb begin
      busy_nxt = busy_q;
      if (oWrEn)  busy_nxt[oWrAddr]  = 1'b0;
      if (iRsvEn) busy_nxt[iRsvAddr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy_q <= '0;
      else       busy_q <= busy_nxt;
   end

   assign oBusy = busy_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_rf_wb_arb;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int LD_DEPTH = 2;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk;
   logic          rstn;
   logic          alu_vld, alu_rdy;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          ld_vld, ld_rdy;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          rsv_en;
   logic [AW-1:0] rsv_addr;
   logic [15:0]   busy;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   int checks = 0;
   int errors = 0;

   // Reference model state: pending loads in push order, busy set, and the expected write port.
   ent_t        ldq[$];
   logic [15:0] mbusy;
   logic        m_wren;
   logic [3:0]  m_wraddr;
   logic [31:0] m_wrdata;

   rf_wb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LD_DEPTH(LD_DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .iAluVld(alu_vld), .oAluRdy(alu_rdy), .iAluAddr(alu_addr), .iAluData(alu_data),
      .iLdVld(ld_vld), .oLdRdy(ld_rdy), .iLdAddr(ld_addr), .iLdData(ld_data),
      .iRsvEn(rsv_en), .iRsvAddr(rsv_addr), .oBusy(busy),
      .oWrEn(wr_en), .oWrAddr(wr_addr), .oWrData(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      alu_vld = 0; alu_addr = '0; alu_data = '0;
      ld_vld = 0;  ld_addr = '0;  ld_data = '0;
      rsv_en = 0;  rsv_addr = '0;
   endtask

   task automatic model_reset();
      ldq.delete();
      mbusy = '0; m_wren = 0; m_wraddr = '0; m_wrdata = '0;
   endtask

   task automatic check_outputs();
      chk("alu_rdy", 32'(alu_rdy), 32'(ldq.size() < LD_DEPTH));
      chk("ld_rdy", 32'(ld_rdy), 32'(ldq.size() < LD_DEPTH));
      chk("wr_en", 32'(wr_en), 32'(m_wren));
      chk("busy", 32'(busy), 32'(mbusy));
      if (m_wren) begin
         chk("wr_addr", 32'(wr_addr), 32'(m_wraddr));
         chk("wr_data", wr_data, m_wrdata);
      end
   endtask

   // One clock: advance the model with the currently driven inputs, then compare after the edge.
   task automatic tick();
      ent_t        g;
      logic        gv;
      logic        full;
      logic [15:0] nb;
      full = (ldq.size() == LD_DEPTH);
      gv = 0;
      g  = '0;
      if (full || (!alu_vld && ldq.size() > 0)) begin
         g  = ldq.pop_front();
         gv = 1;
      end else if (alu_vld) begin
         g.a = alu_addr; g.d = alu_data; gv = 1;
      end
      if (ld_vld && !full) ldq.push_back({ld_addr, ld_data});
      nb = mbusy;
      if (m_wren) nb[m_wraddr] = 1'b0;
      if (rsv_en && rsv_addr != 0) nb[rsv_addr] = 1'b1;
      mbusy = nb;
      if (gv && g.a != 0) begin
         m_wren = 1; m_wraddr = g.a; m_wrdata = g.d;
      end else begin
         m_wren = 0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Called just after a falling edge: asserts reset away from the rising edge and releases it later.
   task automatic do_reset(input string tag);
      set_idle();
      #2 rstn = 0;
      #1;
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, wr_data, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ld_rdy"}, 32'(ld_rdy), 32'd1);
      model_reset();
      @(negedge clk);
      #2 rstn = 1;
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      ent_t lds[3];
      ent_t wlog[$];
      int   li;
      logic acc;

      rstn = 1;
      model_reset();

      // Reset values
      do_reset("reset");
      chk("reset_alu_rdy", 32'(alu_rdy), 32'd1);

      // ALU write with reservation
      rsv_en = 1; rsv_addr = 4'd5;
      tick();
      chk("t2_busy5_set", 32'(busy[5]), 32'd1);
      set_idle();
      tick();
      tick();
      alu_vld = 1; alu_addr = 4'd5; alu_data = 32'hDEADBEEF;
      tick();
      chk("t2_wr_en", 32'(wr_en), 32'd1);
      chk("t2_wr_addr", 32'(wr_addr), 32'd5);
      chk("t2_wr_data", wr_data, 32'hDEADBEEF);
      chk("t2_busy5_held", 32'(busy[5]), 32'd1);
      set_idle();
      tick();
      chk("t2_busy5_clr", 32'(busy[5]), 32'd0);

      // Load starvation under continuous ALU traffic
      lds[0] = {4'd1, 32'h11};
      lds[1] = {4'd2, 32'h22};
      lds[2] = {4'd3, 32'h33};
      li = 0;
      for (int c = 0; c < 12; c++) begin
         alu_vld = (c < 8); alu_addr = 4'd9; alu_data = 32'(c);
         ld_vld = (li < 3);
         if (li < 3) {ld_addr, ld_data} = lds[li];
         acc = ld_vld && (ldq.size() < LD_DEPTH);
         tick();
         if (acc) li++;
         if (c == 1) begin
            chk("t3_ld_rdy_full", 32'(ld_rdy), 32'd0);
            chk("t3_alu_rdy_full", 32'(alu_rdy), 32'd0);
         end
         if (wr_en && wr_addr != 4'd9) wlog.push_back({wr_addr, wr_data});
      end
      set_idle();
      chk("t3_nloads", wlog.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < wlog.size()) chk("t3_load_order", 32'(wlog[i].a), 32'(lds[i].a));
         if (i < wlog.size()) chk("t3_load_data", wlog[i].d, lds[i].d);
      end

      // Address 0 suppression
      alu_vld = 1; alu_addr = 4'd0; alu_data = 32'hFFFFFFFF;
      chk("t4_alu_rdy", 32'(alu_rdy), 32'd1);
      tick();
      chk("t4_wr_en", 32'(wr_en), 32'd0);
      set_idle();
      rsv_en = 1; rsv_addr = 4'd0;
      tick();
      chk("t4_busy0", 32'(busy[0]), 32'd0);
      set_idle();

      // Set/clear collision on the same and on different registers
      alu_vld = 1; alu_addr = 4'd7; alu_data = 32'h77;
      tick();
      chk("t5_wr_addr7", 32'(wr_addr), 32'd7);
      set_idle();
      rsv_en = 1; rsv_addr = 4'd7;
      tick();
      chk("t5_busy7_setwins", 32'(busy[7]), 32'd1);
      set_idle();
      alu_vld = 1; alu_addr = 4'd7; alu_data = 32'h78;
      tick();
      set_idle();
      rsv_en = 1; rsv_addr = 4'd8;
      tick();
      chk("t5_busy7_clr", 32'(busy[7]), 32'd0);
      chk("t5_busy8_set", 32'(busy[8]), 32'd1);
      set_idle();
      tick();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         alu_vld  = ($urandom_range(0, 2) != 0);
         alu_addr = 4'($urandom_range(0, 15));
         alu_data = $urandom;
         ld_vld   = ($urandom_range(0, 1) != 0);
         ld_addr  = 4'($urandom_range(0, 15));
         ld_data  = $urandom;
         rsv_en   = ($urandom_range(0, 1) != 0);
         rsv_addr = 4'($urandom_range(0, 15));
         tick();
      end
      set_idle();
      tick();

      // Reset mid-stream with a full FIFO and pending reservations
      do_reset("pre_t6");
      rsv_en = 1; rsv_addr = 4'd1;
      alu_vld = 1; alu_addr = 4'd9; alu_data = 32'h9;
      ld_vld = 1; ld_addr = 4'd4; ld_data = 32'h44;
      tick();
      rsv_addr = 4'd2; ld_addr = 4'd5; ld_data = 32'h55;
      tick();
      chk("t6_busy_pre", 32'(busy), 32'h0006);
      chk("t6_ld_rdy_pre", 32'(ld_rdy), 32'd0);
      do_reset("t6");
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t6_no_write", 32'(wr_en), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
